qeciphy_traffic_chk: RTL and testbench

Synthesizable AXI-Stream traffic generator and checker that sits directly upstream and downstream of a QECIPHY instance on the ACLK side. It drives a deterministic 64-bit sequence into the PHY TX port and checks the PHY RX port against the same sequence. It reports beat counts, error counts, the first error index and a pass/fail verdict. It is used in on-board link bring-up and as a self-checking stage in system benches.

---
 rtl/qeciphy_pkg.sv | 21 ++
 rtl/qeciphy_traffic_chk_if.sv | 30 +++
 rtl/qeciphy_pattern_gen.sv | 37 +++
 rtl/qeciphy_traffic_chk.sv | 196 +++++++++++++++++++
 tb/tb_qeciphy_traffic_chk.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/qeciphy_pkg.sv
// Shared types, constants and helpers for the QECIPHY traffic generator/checker.
package qeciphy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINK = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } qeciphy_traffic_state_t;

  localparam logic [63:0] QECIPHY_TRAFFIC_DEFAULT_SEED = 64'h0123_4567_89AB_CDEF;

  function automatic logic [63:0] qeciphy_xorshift64_next(input logic [63:0] i_x);
    logic [63:0] v;
    v = i_x ^ (i_x << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

endpackage

// File: rtl/qeciphy_traffic_chk_if.sv
// Stream and status bundle between the traffic checker (master) and its surroundings (slave).
interface qeciphy_traffic_chk_if;
  logic [63:0] TX_TDATA;
  logic        TX_TVALID;
  logic        TX_TREADY;
  logic [63:0] RX_TDATA;
  logic        RX_TVALID;
  logic        RX_TREADY;
  logic [31:0] TX_CNT;
  logic [31:0] RX_CNT;
  logic [31:0] ERR_CNT;
  logic [31:0] FIRST_ERR_IDX;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic        TIMEOUT;
  logic        LINK_LOST;

  modport master (
    output TX_TDATA, TX_TVALID, RX_TREADY,
    output TX_CNT, RX_CNT, ERR_CNT, FIRST_ERR_IDX, BUSY, DONE, PASS, TIMEOUT, LINK_LOST,
    input  TX_TREADY, RX_TDATA, RX_TVALID
  );

  modport slave (
    input  TX_TDATA, TX_TVALID, RX_TREADY,
    input  TX_CNT, RX_CNT, ERR_CNT, FIRST_ERR_IDX, BUSY, DONE, PASS, TIMEOUT, LINK_LOST,
    output TX_TREADY, RX_TDATA, RX_TVALID
  );
endinterface

// File: rtl/qeciphy_pattern_gen.sv
// Deterministic 64-bit pattern source: beat index ("counter") or xorshift64 ("random").
module qeciphy_pattern_gen
  import qeciphy_pkg::*;
#(
  parameter string       PATTERN = "random",
  parameter logic [63:0] SEED    = QECIPHY_TRAFFIC_DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reseed,
  input  logic        i_advance,
  output logic [63:0] o_value
);
  localparam bit          IS_COUNTER = (PATTERN == "counter");
  localparam logic [63:0] VALUE0     = IS_COUNTER ? 64'd0 : SEED;

  logic [63:0] r_value;
  logic [63:0] w_next;

  always_comb begin
    w_next = r_value;
    if (i_reseed) begin
      w_next = VALUE0;
    end else if (i_advance) begin
      w_next = IS_COUNTER ? (r_value + 64'd1) : qeciphy_xorshift64_next(r_value);
    end else begin
      w_next = r_value;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_value <= VALUE0;
    else       r_value <= w_next;
  end

  assign o_value = r_value;
endmodule

// File: rtl/qeciphy_traffic_chk.sv
// AXI-Stream traffic generator/checker for QECIPHY link bring-up.
// Optional TX bit-0 error injection (INJECT_ERR port) exists when QECIPHY_TRAFFIC_ERR_INJECT_EN is defined.
module qeciphy_traffic_chk
  import qeciphy_pkg::*;
#(
  parameter logic [31:0] SEQ_LEN        = 32'd2048,
  parameter string       PATTERN        = "random",
  parameter logic [63:0] SEED           = QECIPHY_TRAFFIC_DEFAULT_SEED,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h0002_0000
) (
  input  logic ACLK,
  input  logic ARST,
  input  logic START,
  input  logic LINK_READY,
`ifdef QECIPHY_TRAFFIC_ERR_INJECT_EN
  input  logic INJECT_ERR,
`endif
  qeciphy_traffic_chk_if.master bus
);
  qeciphy_traffic_state_t r_state, w_state_n;

  logic [31:0] r_tx_cnt, r_rx_cnt, r_err_cnt, r_first_err_idx, r_mis_idx, r_cyc_cnt;
  logic [31:0] w_tx_cnt_n, w_rx_cnt_n, w_err_cnt_n, w_first_n, w_mis_idx_n, w_cyc_n;
  logic        r_mis, r_ovr, r_timeout, r_link_lost, r_tx_valid, r_rx_ready;
  logic        r_busy, r_done, r_pass;
  logic        w_mis_n, w_ovr_n, w_timeout_n, w_link_lost_n, w_tx_valid_n;
  logic        w_start, w_tx_hs, w_rx_hs, w_rx_cmp, w_rx_ovr, w_complete, w_to_hit, w_active;
  logic [63:0] w_tx_pat, w_rx_exp, w_tx_data;

  assign w_active   = (r_state == ST_WAIT_LINK) || (r_state == ST_RUN);
  assign w_start    = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_tx_hs    = r_tx_valid && bus.TX_TREADY;
  assign w_rx_hs    = r_rx_ready && bus.RX_TVALID;
  assign w_rx_cmp   = w_rx_hs && w_active && (r_rx_cnt < SEQ_LEN);
  assign w_rx_ovr   = w_rx_hs && ((r_state == ST_RUN) || (r_state == ST_DONE)) && (r_rx_cnt == SEQ_LEN);
  assign w_complete = (r_tx_cnt == SEQ_LEN) && (r_rx_cnt == SEQ_LEN);

  // Next-state logic; completion takes priority over a coincident timeout.
  always_comb begin
    w_state_n = r_state;
    w_to_hit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) w_state_n = ST_WAIT_LINK;
        else       w_state_n = ST_IDLE;
      end
      ST_WAIT_LINK: begin
        if (r_cyc_cnt == TIMEOUT_CYCLES) begin
          w_state_n = ST_DONE;
          w_to_hit  = 1'b1;
        end else if (LINK_READY) begin
          w_state_n = ST_RUN;
        end else begin
          w_state_n = ST_WAIT_LINK;
        end
      end
      ST_RUN: begin
        if (w_complete) begin
          w_state_n = ST_DONE;
        end else if (r_cyc_cnt == TIMEOUT_CYCLES) begin
          w_state_n = ST_DONE;
          w_to_hit  = 1'b1;
        end else begin
          w_state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (START) w_state_n = ST_WAIT_LINK;
        else       w_state_n = ST_DONE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Counter/flag updates; RX compare results land in ERR_CNT one cycle after the handshake.
  always_comb begin
    w_tx_cnt_n    = r_tx_cnt;
    w_rx_cnt_n    = r_rx_cnt;
    w_err_cnt_n   = r_err_cnt;
    w_first_n     = r_first_err_idx;
    w_mis_idx_n   = r_mis_idx;
    w_cyc_n       = r_cyc_cnt;
    w_mis_n       = 1'b0;
    w_ovr_n       = 1'b0;
    w_timeout_n   = r_timeout;
    w_link_lost_n = r_link_lost;
    if (w_start) begin
      w_tx_cnt_n    = 32'd0;
      w_rx_cnt_n    = 32'd0;
      w_err_cnt_n   = 32'd0;
      w_first_n     = 32'hFFFF_FFFF;
      w_mis_idx_n   = 32'd0;
      w_cyc_n       = 32'd0;
      w_timeout_n   = 1'b0;
      w_link_lost_n = 1'b0;
    end else begin
      if (w_tx_hs) w_tx_cnt_n = r_tx_cnt + 32'd1;
      else         w_tx_cnt_n = r_tx_cnt;
      if (w_rx_cmp) begin
        w_rx_cnt_n  = r_rx_cnt + 32'd1;
        w_mis_n     = (bus.RX_TDATA != w_rx_exp);
        w_mis_idx_n = r_rx_cnt;
      end else begin
        w_ovr_n = w_rx_ovr;
      end
      if ((r_mis || r_ovr) && (r_err_cnt != 32'hFFFF_FFFF)) w_err_cnt_n = r_err_cnt + 32'd1;
      else                                                   w_err_cnt_n = r_err_cnt;
      // An index of all-ones can never be a real beat index, so it doubles as "unset".
      if (r_mis && (r_first_err_idx == 32'hFFFF_FFFF)) w_first_n = r_mis_idx;
      else                                             w_first_n = r_first_err_idx;
      if (w_active && (r_cyc_cnt != TIMEOUT_CYCLES)) w_cyc_n = r_cyc_cnt + 32'd1;
      else                                           w_cyc_n = r_cyc_cnt;
      w_timeout_n   = r_timeout | w_to_hit;
      w_link_lost_n = r_link_lost | ((r_state == ST_RUN) && !LINK_READY);
    end
    w_tx_valid_n = (r_state == ST_RUN) && (w_state_n == ST_RUN) && (w_tx_cnt_n < SEQ_LEN);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_state         <= ST_IDLE;
      r_tx_cnt        <= 32'd0;
      r_rx_cnt        <= 32'd0;
      r_err_cnt       <= 32'd0;
      r_first_err_idx <= 32'hFFFF_FFFF;
      r_mis_idx       <= 32'd0;
      r_cyc_cnt       <= 32'd0;
      r_mis           <= 1'b0;
      r_ovr           <= 1'b0;
      r_timeout       <= 1'b0;
      r_link_lost     <= 1'b0;
      r_tx_valid      <= 1'b0;
      r_rx_ready      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_tx_cnt        <= w_tx_cnt_n;
      r_rx_cnt        <= w_rx_cnt_n;
      r_err_cnt       <= w_err_cnt_n;
      r_first_err_idx <= w_first_n;
      r_mis_idx       <= w_mis_idx_n;
      r_cyc_cnt       <= w_cyc_n;
      r_mis           <= w_mis_n;
      r_ovr           <= w_ovr_n;
      r_timeout       <= w_timeout_n;
      r_link_lost     <= w_link_lost_n;
      r_tx_valid      <= w_tx_valid_n;
      r_rx_ready      <= 1'b1;
      r_busy          <= (w_state_n == ST_WAIT_LINK) || (w_state_n == ST_RUN);
      r_done          <= (w_state_n == ST_DONE);
      r_pass          <= (w_state_n == ST_DONE) && (w_err_cnt_n == 32'd0) && !w_timeout_n;
    end
  end

  qeciphy_pattern_gen #(.PATTERN(PATTERN), .SEED(SEED)) u_tx_gen (
    .i_clk(ACLK), .i_rst(ARST), .i_reseed(w_start), .i_advance(w_tx_hs), .o_value(w_tx_pat)
  );

  qeciphy_pattern_gen #(.PATTERN(PATTERN), .SEED(SEED)) u_rx_gen (
    .i_clk(ACLK), .i_rst(ARST), .i_reseed(w_start), .i_advance(w_rx_cmp), .o_value(w_rx_exp)
  );

`ifdef QECIPHY_TRAFFIC_ERR_INJECT_EN
  logic r_inj_used;
  logic w_inj;

  assign w_inj     = INJECT_ERR && !r_inj_used && r_tx_valid;
  assign w_tx_data = w_tx_pat ^ {63'd0, w_inj};

  // One corrupted beat per INJECT_ERR high period; re-armed when INJECT_ERR drops.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST)                     r_inj_used <= 1'b0;
    else if (!INJECT_ERR)         r_inj_used <= 1'b0;
    else if (w_inj && w_tx_hs)    r_inj_used <= 1'b1;
    else                          r_inj_used <= r_inj_used;
  end
`else
  assign w_tx_data = w_tx_pat;
`endif

  assign bus.TX_TDATA      = w_tx_data;
  assign bus.TX_TVALID     = r_tx_valid;
  assign bus.RX_TREADY     = r_rx_ready;
  assign bus.TX_CNT        = r_tx_cnt;
  assign bus.RX_CNT        = r_rx_cnt;
  assign bus.ERR_CNT       = r_err_cnt;
  assign bus.FIRST_ERR_IDX = r_first_err_idx;
  assign bus.BUSY          = r_busy;
  assign bus.DONE          = r_done;
  assign bus.PASS          = r_pass;
  assign bus.TIMEOUT       = r_timeout;
  assign bus.LINK_LOST     = r_link_lost;
endmodule

// File: tb/tb_qeciphy_traffic_chk.sv
// Directed bench: a random-pattern instance run from a scenario table, plus a counter-pattern instance with stalls.
module tb_qeciphy_traffic_chk;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  logic ACLK = 1'b0;
  logic ARST = 1'b1;
  logic LINK_READY = 1'b0;
  logic start_r = 1'b0, start_c = 1'b0;
  logic mon_clr = 1'b0, mon_clr_c = 1'b0;
  logic extra_v = 1'b0;
  int   flip_idx = -1;

  int n_vec = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  qeciphy_traffic_chk_if bus_r();
  qeciphy_traffic_chk_if bus_c();

  qeciphy_traffic_chk #(.SEQ_LEN(32'd128), .PATTERN("random"), .SEED(SEED), .TIMEOUT_CYCLES(32'd400)) u_rnd (
    .ACLK(ACLK), .ARST(ARST), .START(start_r), .LINK_READY(LINK_READY), .bus(bus_r)
  );

  qeciphy_traffic_chk #(.SEQ_LEN(32'd16), .PATTERN("counter"), .SEED(SEED), .TIMEOUT_CYCLES(32'd400)) u_cnt (
    .ACLK(ACLK), .ARST(ARST), .START(start_c), .LINK_READY(LINK_READY), .bus(bus_c)
  );

  // Loopback with optional single-beat corruption (bit 5) and a bench-injected extra beat.
  int          rx_idx = 0;
  logic [63:0] model = SEED;
  int          tx_seq_err = 0;

  assign bus_r.RX_TVALID = extra_v ? 1'b1 : (bus_r.TX_TVALID & bus_r.TX_TREADY);
  assign bus_r.RX_TDATA  = extra_v ? 64'hDEAD_BEEF_0000_0001
                                   : (bus_r.TX_TDATA ^ ((rx_idx == flip_idx) ? 64'h0000_0000_0000_0020 : 64'd0));
  assign bus_c.RX_TVALID = bus_c.TX_TVALID & bus_c.TX_TREADY;
  assign bus_c.RX_TDATA  = bus_c.TX_TDATA;

  function automatic logic [63:0] tb_xs(input logic [63:0] x);
    logic [63:0] t;
    t = x;
    t = t ^ {t[50:0], 13'd0};
    t = t ^ {7'd0, t[63:7]};
    t = t ^ {t[46:0], 17'd0};
    return t;
  endfunction

  always @(posedge ACLK) begin
    if (mon_clr) begin
      rx_idx     <= 0;
      model      <= SEED;
      tx_seq_err <= 0;
    end else if (bus_r.TX_TVALID && bus_r.TX_TREADY) begin
      if (bus_r.TX_TDATA !== model) tx_seq_err <= tx_seq_err + 1;
      model  <= tb_xs(model);
      rx_idx <= rx_idx + 1;
    end
  end

  int          c_idx = 0;
  int          c_err = 0;
  logic        c_hold_v = 1'b0;
  logic [63:0] c_hold_d = 64'd0;

  always @(posedge ACLK) begin
    int e;
    if (mon_clr_c) begin
      c_idx    <= 0;
      c_err    <= 0;
      c_hold_v <= 1'b0;
    end else begin
      e = c_err;
      if (c_hold_v && (!bus_c.TX_TVALID || bus_c.TX_TDATA !== c_hold_d)) e = e + 1;
      if (bus_c.TX_TVALID && bus_c.TX_TREADY) begin
        if (bus_c.TX_TDATA !== 64'(c_idx)) e = e + 1;
        c_idx <= c_idx + 1;
      end
      c_err    <= e;
      c_hold_v <= bus_c.TX_TVALID && !bus_c.TX_TREADY;
      c_hold_d <= bus_c.TX_TDATA;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        link;
    int          flip;
    logic        extra;
    logic [31:0] etx;
    logic [31:0] erx;
    logic [31:0] eerr;
    logic [31:0] efirst;
    logic        epass;
    logic        eto;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1,  -1, 1'b0, 32'd128, 32'd128, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 100, 1'b0, 32'd128, 32'd128, 32'd1, 32'd100,       1'b0, 1'b0};
    vecs[2] = '{1'b1,   0, 1'b0, 32'd128, 32'd128, 32'd1, 32'd0,         1'b0, 1'b0};
    vecs[3] = '{1'b1,  -1, 1'b1, 32'd128, 32'd128, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{1'b0,  -1, 1'b0, 32'd0,   32'd0,   32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 127, 1'b0, 32'd128, 32'd128, 32'd1, 32'd127,       1'b0, 1'b0};

    bus_r.TX_TREADY = 1'b1;
    bus_c.TX_TREADY = 1'b0;

    // Reset values while ARST is held.
    #12;
    chk("rst.tx_tdata_rnd", bus_r.TX_TDATA, SEED);
    chk("rst.tx_tdata_cnt", bus_c.TX_TDATA, 64'd0);
    chk("rst.first_err_idx", 64'(bus_r.FIRST_ERR_IDX), 64'h0000_0000_FFFF_FFFF);
    chk("rst.tx_cnt", 64'(bus_r.TX_CNT), 64'd0);
    chk("rst.status", {59'd0, bus_r.BUSY, bus_r.DONE, bus_r.PASS, bus_r.TIMEOUT, bus_r.LINK_LOST}, 64'd0);
    chk("rst.rx_tready", 64'(bus_r.RX_TREADY), 64'd0);
    @(negedge ACLK);
    ARST = 1'b0;
    @(negedge ACLK);
    chk("rst.rx_tready_after", 64'(bus_r.RX_TREADY), 64'd1);

    // Counter pattern, random back-pressure, START pulse mid-run must be ignored.
    LINK_READY = 1'b1;
    start_c = 1'b1; mon_clr_c = 1'b1;
    @(negedge ACLK);
    start_c = 1'b0; mon_clr_c = 1'b0;
    for (int c = 0; c < 300 && !bus_c.DONE; c++) begin
      bus_c.TX_TREADY = 1'($urandom_range(0, 1));
      start_c = (c == 8);
      @(negedge ACLK);
    end
    start_c = 1'b0;
    chk("cnt.done", 64'(bus_c.DONE), 64'd1);
    chk("cnt.pass", 64'(bus_c.PASS), 64'd1);
    chk("cnt.tx_cnt", 64'(bus_c.TX_CNT), 64'd16);
    chk("cnt.rx_cnt", 64'(bus_c.RX_CNT), 64'd16);
    chk("cnt.err_cnt", 64'(bus_c.ERR_CNT), 64'd0);
    chk("cnt.beats_seen", 64'(c_idx), 64'd16);
    chk("cnt.stream_errs", 64'(c_err), 64'd0);

    // Scenario table on the random-pattern instance.
    for (int i = 0; i < 6; i++) begin
      LINK_READY = vecs[i].link;
      flip_idx   = vecs[i].flip;
      start_r = 1'b1; mon_clr = 1'b1;
      @(negedge ACLK);
      start_r = 1'b0; mon_clr = 1'b0;
      chk($sformatf("v%0d.busy", i), 64'(bus_r.BUSY), 64'd1);
      for (int c = 0; c < 600 && !bus_r.DONE; c++) @(negedge ACLK);
      chk($sformatf("v%0d.done", i), 64'(bus_r.DONE), 64'd1);
      if (vecs[i].extra) begin
        extra_v = 1'b1;
        @(negedge ACLK);
        extra_v = 1'b0;
        @(negedge ACLK);
      end
      @(negedge ACLK);
      chk($sformatf("v%0d.tx_cnt", i), 64'(bus_r.TX_CNT), 64'(vecs[i].etx));
      chk($sformatf("v%0d.rx_cnt", i), 64'(bus_r.RX_CNT), 64'(vecs[i].erx));
      chk($sformatf("v%0d.err_cnt", i), 64'(bus_r.ERR_CNT), 64'(vecs[i].eerr));
      chk($sformatf("v%0d.first_err_idx", i), 64'(bus_r.FIRST_ERR_IDX), 64'(vecs[i].efirst));
      chk($sformatf("v%0d.pass", i), 64'(bus_r.PASS), 64'(vecs[i].epass));
      chk($sformatf("v%0d.timeout", i), 64'(bus_r.TIMEOUT), 64'(vecs[i].eto));
      chk($sformatf("v%0d.busy_end", i), 64'(bus_r.BUSY), 64'd0);
      chk($sformatf("v%0d.tx_seq", i), 64'(tx_seq_err), 64'd0);
    end
    flip_idx = -1;

    // Link drop mid-run, then asynchronous reset.
    LINK_READY = 1'b1;
    start_r = 1'b1; mon_clr = 1'b1;
    @(negedge ACLK);
    start_r = 1'b0; mon_clr = 1'b0;
    repeat (20) @(negedge ACLK);
    LINK_READY = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("ll.link_lost", 64'(bus_r.LINK_LOST), 64'd1);
    chk("ll.busy", 64'(bus_r.BUSY), 64'd1);
    #2 ARST = 1'b1;
    #1;
    chk("ll.rst_status", {59'd0, bus_r.BUSY, bus_r.DONE, bus_r.PASS, bus_r.TIMEOUT, bus_r.LINK_LOST}, 64'd0);
    chk("ll.rst_tx_cnt", 64'(bus_r.TX_CNT), 64'd0);
    chk("ll.rst_tx_tvalid", 64'(bus_r.TX_TVALID), 64'd0);
    chk("ll.rst_tx_tdata", bus_r.TX_TDATA, SEED);
    chk("ll.rst_first_err_idx", 64'(bus_r.FIRST_ERR_IDX), 64'h0000_0000_FFFF_FFFF);
    chk("ll.rst_rx_tready", 64'(bus_r.RX_TREADY), 64'd0);
    @(negedge ACLK);
    ARST = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("ll.idle_busy", 64'(bus_r.BUSY), 64'd0);
    chk("ll.idle_rx_cnt", 64'(bus_r.RX_CNT), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
